mul_iter: RTL and testbench

Sequential signed/unsigned 32×32 multiplier producing a 64-bit product in HI/LO registers. It is the multiply counterpart to the combinational divider in the P6 datapath, and sits beside the ALU in the EX stage. It accepts one operation per start pulse, computes it by radix-2 shift-add over WIDTH cycles, and reports completion with a one-cycle done pulse. Pipeline control stalls on `busy`.

---
 rtl/mul_iter.sv | 121 ++++++++++++
 tb/tb_mul_iter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned, WIDTH x WIDTH -> 2*WIDTH.
// One operation per start; result lands in hi/lo with a one-cycle done pulse.
module mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_sign,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             r_state, w_state_d;
    logic [2*WIDTH-1:0] r_mcand, w_mcand_d;
    logic [WIDTH-1:0]   r_mplier, w_mplier_d;
    logic [2*WIDTH-1:0] r_acc, w_acc_d;
    logic [CntW-1:0]    r_cnt, w_cnt_d;
    logic               r_neg, w_neg_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;
    logic [WIDTH-1:0]   r_hi, w_hi_d;
    logic [WIDTH-1:0]   r_lo, w_lo_d;

    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [2*WIDTH-1:0] w_result;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign w_abs_a  = (i_sign && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_abs_b  = (i_sign && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_result = r_neg ? -r_acc : r_acc;

    always_comb begin
        w_state_d  = r_state;
        w_mcand_d  = r_mcand;
        w_mplier_d = r_mplier;
        w_acc_d    = r_acc;
        w_cnt_d    = r_cnt;
        w_neg_d    = r_neg;
        w_busy_d   = r_busy;
        w_done_d   = 1'b0;
        w_hi_d     = r_hi;
        w_lo_d     = r_lo;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_mcand_d  = {{WIDTH{1'b0}}, w_abs_a};
                    w_mplier_d = w_abs_b;
                    w_neg_d    = i_sign & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                    w_acc_d    = '0;
                    w_cnt_d    = '0;
                    w_busy_d   = 1'b1;
                    w_state_d  = StRun;
                end
            end
            StRun: begin
                if (r_mplier[0]) begin
                    w_acc_d = r_acc + r_mcand;
                end
                w_mcand_d  = r_mcand << 1;
                w_mplier_d = r_mplier >> 1;
                w_cnt_d    = r_cnt + CntW'(1);
                if (r_cnt == CntLast) begin
                    w_state_d = StFix;
                end
            end
            StFix: begin
                w_hi_d    = w_result[2*WIDTH-1:WIDTH];
                w_lo_d    = w_result[WIDTH-1:0];
                w_done_d  = 1'b1;
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= StIdle;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state  <= w_state_d;
            r_mcand  <= w_mcand_d;
            r_mplier <= w_mplier_d;
            r_acc    <= w_acc_d;
            r_cnt    <= w_cnt_d;
            r_neg    <= w_neg_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_hi     <= w_hi_d;
            r_lo     <= w_lo_d;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: timing/arithmetic reference model checked every cycle, plus
// directed operand cases with literal expected products.
module tb_mul_iter;

    localparam int unsigned W = 32;

    logic         clk;
    logic         i_reset;
    logic         i_start;
    logic         i_sign;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;

    mul_iter #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_sign  (i_sign),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start occupies WIDTH+1 busy cycles, then the product appears.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_res  = '0;

    always @(posedge clk) begin
        if (!i_reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res  = m_pend;
                    m_done = 1'b1;
                end
            end else if (i_start) begin
                m_pend = prod(i_sign, i_a, i_b);
                m_left = W + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(o_busy), 64'(m_left != 0));
        check("done", 64'(o_done), 64'(m_done));
        check("hilo", {o_hi, o_lo}, m_res);
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        i_sign  = s;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Called in cycle 1; returns in the done cycle with the cycle number in lat.
    task automatic wait_done(input bit noise, output int lat);
        lat = 1;
        while (o_done !== 1'b1 && lat < 60) begin
            if (noise) begin
                i_start = 1'($urandom_range(0, 1));
                i_sign  = 1'($urandom_range(0, 1));
                i_a     = $urandom;
                i_b     = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        i_start = 1'b0;
        if (o_done !== 1'b1) begin
            n_total++;
            n_bad++;
            $display("FAIL timeout: no done within %0d cycles", lat);
        end
    endtask

    task automatic run_lit(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int lat;
        start_op(s, a, b);
        wait_done(1'b0, lat);
        check({name, "_lat"}, 64'(lat), 64'(W + 2));
        check(name, {o_hi, o_lo}, exp);
    endtask

    logic [31:0] pick[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF};

    initial begin
        int lat;
        int d0;
        logic [31:0] ra;
        logic [31:0] rb;
        i_reset = 1'b0;
        i_start = 1'b1;
        i_sign  = 1'b1;
        i_a     = 32'hFFFF_FFFF;
        i_b     = 32'h2;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_hilo", {o_hi, o_lo}, 64'd0);
        i_reset = 1'b1;
        i_start = 1'b0;
        @(negedge clk);

        run_lit("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_lit("sneg1", 1'b1, 32'hFFFF_FFFF, 32'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_lit("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_lit("sm7x6", 1'b1, 32'hFFFF_FFF9, 32'h6, 64'hFFFF_FFFF_FFFF_FFD6);
        run_lit("umin2", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        @(negedge clk);

        // Start and operand changes while busy must be ignored.
        d0 = done_cnt;
        start_op(1'b0, 32'd3, 32'd5);
        repeat (8) @(negedge clk);
        i_start = 1'b1;
        i_a     = 32'd9;
        i_b     = 32'd9;
        i_sign  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_a     = 32'hDEAD_BEEF;
        i_sign  = 1'b0;
        lat = 10;
        while (o_done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("iso_lat", 64'(lat), 64'(W + 2));
        check("iso_res", {o_hi, o_lo}, 64'd15);
        repeat (40) @(negedge clk);
        check("iso_ndone", 64'(done_cnt - d0), 64'd1);

        // Reset mid-operation aborts with no done and clears hi/lo.
        d0 = done_cnt;
        start_op(1'b0, 32'hFFFF, 32'hFFFF);
        repeat (18) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        check("abort_busy", 64'(o_busy), 64'd0);
        check("abort_hilo", {o_hi, o_lo}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort_ndone", 64'(done_cnt - d0), 64'd0);

        // Back-to-back: new start in the done cycle.
        run_lit("b2b_a", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_lit("b2b_b", 1'b0, 32'h0, 32'h1234_5678, 64'd0);

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
            start_op(1'($urandom_range(0, 1)), ra, rb);
            wait_done(1'b1, lat);
            check("rnd_lat", 64'(lat), 64'(W + 2));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
